// File: rtl/wmst_burst_arbiter.sv
// Round-robin arbiter sharing one write-master command port and one beat stream between NUM_REQ burst producers.
// Optional watchdog: define WMST_ARB_TIMEOUT_EN to enable the XFER stall timeout (sticky timeout_err).
module wmst_burst_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 512,
    parameter int BEAT_BYTES = 64,
    parameter int TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*64-1:0]     req_addr_i,
    input  logic [NUM_REQ*64-1:0]     req_size_i,
    output logic [NUM_REQ-1:0]        req_done_o,
    input  logic [NUM_REQ*DATA_W-1:0] s_tdata_i,
    input  logic [NUM_REQ-1:0]        s_valid_i,
    output logic [NUM_REQ-1:0]        s_ready_o,
    output logic                      m_wmst_req,
    output logic [63:0]               m_wmst_addr,
    output logic [63:0]               m_wmst_xfer_size,
    input  logic                      m_wmst_done,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int BEAT_SH = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        size_q, size_d;
    logic [63:0]        beats_q, beats_d;
    logic [63:0]        sent_q, sent_d;

    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [63:0]        pick_addr, pick_size, pick_beats;
    logic               g_valid, g_req;
    logic [DATA_W-1:0]  g_data;
    logic               room, beat;

`ifdef WMST_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            terr_q, terr_d;
`endif

    // First pending producer at or after the pointer, with wrap-around.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pick_found && idx == k && pend_q[k]) begin
                    pick_found = 1'b1;
                    pick_idx   = 2'(k);
                end
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        pick_size = '0;
        g_valid   = 1'b0;
        g_req     = 1'b0;
        g_data    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == 2'(k)) begin
                pick_addr = req_addr_i[64*k +: 64];
                pick_size = req_size_i[64*k +: 64];
            end
            if (grant_q == 2'(k)) begin
                g_valid = s_valid_i[k];
                g_req   = req_i[k];
                g_data  = s_tdata_i[DATA_W*k +: DATA_W];
            end
        end
    end

    assign pick_beats = (pick_size >> BEAT_SH)
                      + {63'd0, |(pick_size & 64'(BEAT_BYTES - 1))};

    // Stream handshake: a beat moves when m_valid && m_ready are both high on a rising
    // edge; both are gated by room so nothing past the burst length is accepted.
    assign room = (sent_q < beats_q);
    assign beat = (state_q == S_XFER) && g_valid && m_ready && room;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | req_i;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        size_d     = size_q;
        beats_d    = beats_q;
        sent_d     = sent_q;
        m_wmst_req = 1'b0;
        req_done_o = '0;
        s_ready_o  = '0;
        m_valid    = 1'b0;
        m_tdata    = '0;
`ifdef WMST_ARB_TIMEOUT_EN
        wd_d       = '0;
        terr_d     = terr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = pick_addr;
                    size_d  = pick_size;
                    beats_d = pick_beats;
                    sent_d  = '0;
                    state_d = (pick_size == 64'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_wmst_req = 1'b1;
                state_d    = m_wmst_done ? S_DONE : S_XFER;
            end
            S_XFER: begin
                m_valid = g_valid && room;
                m_tdata = g_data;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (grant_q == 2'(k)) s_ready_o[k] = m_ready && room;
                end
                if (beat) sent_d = sent_q + 64'd1;
                if (m_wmst_done) state_d = S_DONE;
`ifdef WMST_ARB_TIMEOUT_EN
                wd_d = beat ? '0 : wd_q + 1'b1;
                if (!beat && wd_q == WD_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                // A re-request in this cycle keeps the producer armed for a later grant.
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (grant_q == 2'(k)) begin
                        req_done_o[k] = 1'b1;
                        pend_d[k]     = g_req;
                    end
                end
                ptr_d   = (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;
                sent_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            beats_q <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            beats_q <= beats_d;
            sent_q  <= sent_d;
        end
    end

`ifdef WMST_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign m_wmst_addr      = addr_q;
    assign m_wmst_xfer_size = size_q;
    assign grant_id         = grant_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_wmst_burst_arbiter.sv
// Directed bench for wmst_burst_arbiter: producer and write-master models plus per-scenario checks.
module tb_wmst_burst_arbiter;

    localparam int NR = 2;
    localparam int DW = 512;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_i;
    logic [NR*64-1:0] req_addr_i;
    logic [NR*64-1:0] req_size_i;
    logic [NR-1:0]    req_done_o;
    logic [NR*DW-1:0] s_tdata_i;
    logic [NR-1:0]    s_valid_i;
    logic [NR-1:0]    s_ready_o;
    logic             m_wmst_req;
    logic [63:0]      m_wmst_addr;
    logic [63:0]      m_wmst_xfer_size;
    logic             m_wmst_done;
    logic [DW-1:0]    m_tdata;
    logic             m_valid;
    logic             m_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    wmst_burst_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BEAT_BYTES(64), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_done_o(req_done_o),
        .s_tdata_i(s_tdata_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_wmst_req(m_wmst_req), .m_wmst_addr(m_wmst_addr), .m_wmst_xfer_size(m_wmst_xfer_size),
        .m_wmst_done(m_wmst_done), .m_tdata(m_tdata), .m_valid(m_valid), .m_ready(m_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Bench models: producers, write master, backpressure.
    int prod_left[NR];
    int prod_seq[NR];
    int rereq_left[NR];
    int bp_mode;
    int wm_active, wm_cnt, wm_target;

    // Observed events.
    logic [DW-1:0] act_q[$];
    logic [DW-1:0] exp_q[$];
    int            req_cyc_q[$];
    logic [1:0]    req_gnt_q[$];
    logic [63:0]   req_addr_q[$];
    logic [63:0]   req_size_q[$];
    int            done_cyc_q[$];
    logic [NR-1:0] done_val_q[$];
    logic          done_terr_q[$];
    int            done_beats_q[$];

    function automatic logic [DW-1:0] mk_beat(input int k, input int s);
        logic [DW-1:0] b;
        b = '0;
        b[DW-1 -: 16] = 16'(k + 1);
        b[31:0] = s;
        return b;
    endfunction

    task automatic cycle();
        logic [NR-1:0] acc, dn;
        logic          bt, rq;
        logic [63:0]   sz;
        @(negedge clk);
        acc = s_valid_i & s_ready_o;
        dn  = req_done_o;
        bt  = m_valid && m_ready;
        rq  = m_wmst_req;
        sz  = m_wmst_xfer_size;
        if (rq) begin
            req_cyc_q.push_back(cyc);
            req_gnt_q.push_back(grant_id);
            req_addr_q.push_back(m_wmst_addr);
            req_size_q.push_back(m_wmst_xfer_size);
        end
        if (dn != '0) begin
            done_cyc_q.push_back(cyc);
            done_val_q.push_back(dn);
            done_terr_q.push_back(timeout_err);
            done_beats_q.push_back(act_q.size());
        end
        if (bt) act_q.push_back(m_tdata);
        @(posedge clk);
        #1;
        cyc++;
        req_i = '0;
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) begin
                prod_seq[k]++;
                prod_left[k]--;
            end
            if (dn[k] && rereq_left[k] > 0) begin
                req_i[k] = 1'b1;
                rereq_left[k]--;
                prod_left[k]++;
            end
            s_valid_i[k] = (prod_left[k] > 0);
            s_tdata_i[k*DW +: DW] = mk_beat(k, prod_seq[k]);
        end
        m_wmst_done = 1'b0;
        if (rq) begin
            wm_active = 1;
            wm_cnt    = 0;
            wm_target = int'((sz + 64'd63) / 64'd64);
        end else if (bt && wm_active != 0) begin
            wm_cnt++;
        end
        if (wm_active != 0 && wm_target > 0 && wm_cnt == wm_target) begin
            m_wmst_done = 1'b1;
            wm_active   = 0;
        end
        m_ready = (bp_mode != 0) ? ((cyc % 2) == 0) : 1'b1;
    endtask

    task automatic run_until_done(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (done_val_q.size() < n && b < budget) begin
            cycle();
            b++;
        end
        checks++;
        if (done_val_q.size() < n) begin
            errors++;
            $display("FAIL %s_wait: done pulses %0d, required %0d within %0d cycles", name, done_val_q.size(), n, budget);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_i       = '0;
        req_addr_i  = '0;
        req_size_i  = '0;
        s_valid_i   = '0;
        s_tdata_i   = '0;
        m_wmst_done = 1'b0;
        m_ready     = 1'b1;
        bp_mode     = 0;
        wm_active   = 0;
        wm_cnt      = 0;
        wm_target   = 0;
        for (int k = 0; k < NR; k++) begin
            prod_left[k]  = 0;
            prod_seq[k]   = 0;
            rereq_left[k] = 0;
        end
        act_q.delete(); exp_q.delete();
        req_cyc_q.delete(); req_gnt_q.delete(); req_addr_q.delete(); req_size_q.delete();
        done_cyc_q.delete(); done_val_q.delete(); done_terr_q.delete(); done_beats_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic start_req(input int k, input logic [63:0] addr, input logic [63:0] size);
        req_i[k] = 1'b1;
        req_addr_i[64*k +: 64] = addr;
        req_size_i[64*k +: 64] = size;
    endtask

    task automatic check_beats(input string name);
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d beats, expected %0d", name, act_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_beat%0d: got %h expected %h", name, i, act_q[i][31:0], exp_q[i][31:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_i      = '1;
        s_valid_i  = '1;
        m_ready    = 1'b1;
        m_wmst_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_wmst_req, m_valid, busy, timeout_err, grant_id, s_ready_o, req_done_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b val=%b busy=%b terr=%b gnt=%0d rdy=%b done=%b, required all 0",
                     m_wmst_req, m_valid, busy, timeout_err, grant_id, s_ready_o, req_done_o);
        end
        checks++;
        if ({m_wmst_addr, m_wmst_xfer_size} !== 128'd0) begin
            errors++;
            $display("FAIL reset_cmd: got addr=%h size=%h, required 0", m_wmst_addr, m_wmst_xfer_size);
        end
        do_reset();
        repeat (3) cycle();
        checks++;
        if (busy !== 1'b0 || req_cyc_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b cmds=%0d, required 0 and 0", busy, req_cyc_q.size());
        end
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        prod_left[0] = 16;
        for (int i = 0; i < 16; i++) exp_q.push_back(mk_beat(0, i));
        t0 = cyc;
        start_req(0, 64'h1000, 64'd1024);
        run_until_done(1, 100, "single");
        repeat (3) cycle();
        checks++;
        if (req_cyc_q.size() !== 1) begin
            errors++;
            $display("FAIL single_cmds: got %0d commands, required 1", req_cyc_q.size());
        end else begin
            checks++;
            if (req_cyc_q[0] !== t0 + 2) begin
                errors++;
                $display("FAIL single_latency: cmd at %0d, required %0d", req_cyc_q[0], t0 + 2);
            end
            checks++;
            if (req_addr_q[0] !== 64'h1000 || req_size_q[0] !== 64'd1024) begin
                errors++;
                $display("FAIL single_cmd: addr=%h size=%0d, required 1000 and 1024", req_addr_q[0], req_size_q[0]);
            end
        end
        check_beats("single");
        checks++;
        if (done_val_q.size() !== 1 || done_val_q[0] !== 2'b01) begin
            errors++;
            $display("FAIL single_done: %0d pulses first=%b, required 1 pulse 01", done_val_q.size(), done_val_q[0]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_contention();
        do_reset();
        prod_left[0] = 4;
        prod_left[1] = 4;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_beat(0, i));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_beat(1, i));
        start_req(0, 64'h2000, 64'd256);
        start_req(1, 64'h3000, 64'd256);
        run_until_done(2, 150, "contend");
        check_beats("contend");
        checks++;
        if (req_gnt_q.size() !== 2 || req_gnt_q[0] !== 2'd0 || req_gnt_q[1] !== 2'd1) begin
            errors++;
            $display("FAIL contend_grant: %0d cmds, grants %0d,%0d required 0,1", req_gnt_q.size(), req_gnt_q[0], req_gnt_q[1]);
        end
        checks++;
        if (req_addr_q.size() !== 2 || req_addr_q[0] !== 64'h2000 || req_addr_q[1] !== 64'h3000) begin
            errors++;
            $display("FAIL contend_addr: %h,%h required 2000,3000", req_addr_q[0], req_addr_q[1]);
        end
        checks++;
        if (done_val_q.size() !== 2 || done_val_q[0] !== 2'b01 || done_val_q[1] !== 2'b10) begin
            errors++;
            $display("FAIL contend_done: %b,%b required 01,10", done_val_q[0], done_val_q[1]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        prod_left[0] = 1;
        prod_left[1] = 1;
        rereq_left[0] = 2;
        rereq_left[1] = 2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk_beat(0, i));
            exp_q.push_back(mk_beat(1, i));
        end
        start_req(0, 64'h4000, 64'd64);
        start_req(1, 64'h5000, 64'd64);
        run_until_done(6, 300, "rr");
        repeat (4) cycle();
        checks++;
        if (req_gnt_q.size() !== 6) begin
            errors++;
            $display("FAIL rr_cmds: got %0d commands, required 6", req_gnt_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (req_gnt_q[i] !== 2'(i % 2)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got %0d required %0d", i, req_gnt_q[i], i % 2);
                end
            end
        end
        check_beats("rr");
    endtask

    task automatic test_overrun();
        do_reset();
        prod_left[0] = 20;
        for (int i = 0; i < 16; i++) exp_q.push_back(mk_beat(0, i));
        start_req(0, 64'h6000, 64'd1024);
        run_until_done(1, 100, "overrun");
        repeat (4) cycle();
        check_beats("overrun");
        checks++;
        if (prod_left[0] !== 4) begin
            errors++;
            $display("FAIL overrun_left: producer holds %0d beats, required 4", prod_left[0]);
        end
        checks++;
        if (s_valid_i[0] !== 1'b1 || s_ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_block: valid=%b ready=%b, required 1 and 0", s_valid_i[0], s_ready_o[0]);
        end
    endtask

    task automatic test_zero_size();
        int t0;
        do_reset();
        t0 = cyc;
        start_req(1, 64'h7000, 64'd0);
        repeat (6) cycle();
        checks++;
        if (req_cyc_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_cmd: got %0d commands, required 0", req_cyc_q.size());
        end
        checks++;
        if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== t0 + 2 || done_val_q[0] !== 2'b10) begin
            errors++;
            $display("FAIL zero_done: %0d pulses at %0d val %b, required 1 at %0d val 10",
                     done_cyc_q.size(), done_cyc_q[0], done_val_q[0], t0 + 2);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bp_mode = 1;
        prod_left[0] = 16;
        for (int i = 0; i < 16; i++) exp_q.push_back(mk_beat(0, i));
        start_req(0, 64'h8000, 64'd1000);
        run_until_done(1, 200, "bp");
        check_beats("bp");
        checks++;
        if (req_size_q.size() !== 1 || req_size_q[0] !== 64'd1000) begin
            errors++;
            $display("FAIL bp_size: got %0d, required 1000", req_size_q[0]);
        end
        checks++;
        if (done_beats_q.size() !== 1 || done_beats_q[0] !== 16) begin
            errors++;
            $display("FAIL bp_sent: %0d beats before done, required 16", done_beats_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        prod_left[0] = 16;
        start_req(0, 64'h9000, 64'd1024);
        repeat (6) cycle();
        start_req(1, 64'hA000, 64'd64);
        cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_wmst_addr !== 64'd0) begin
            errors++;
            $display("FAIL midreset_clear: busy=%b valid=%b addr=%h, required 0", busy, m_valid, m_wmst_addr);
        end
        do_reset();
        repeat (8) cycle();
        checks++;
        if (req_cyc_q.size() !== 0 || done_val_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_lost: cmds=%0d dones=%0d, required 0 and 0", req_cyc_q.size(), done_val_q.size());
        end
    endtask

    task automatic test_stall();
        int t0;
        do_reset();
        t0 = cyc;
        start_req(0, 64'hB000, 64'd256);
        cycle();
        prod_left[1] = 1;
        start_req(1, 64'hC000, 64'd64);
        exp_q.push_back(mk_beat(1, 0));
        repeat (20) cycle();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: terr=%b busy=%b, required 0 and 1", timeout_err, busy);
        end
`ifdef WMST_ARB_TIMEOUT_EN
        run_until_done(1, 120, "timeout");
        checks++;
        if (done_cyc_q[0] !== t0 + 67 || done_val_q[0] !== 2'b01 || done_terr_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: at %0d val %b terr %b, required %0d 01 1",
                     done_cyc_q[0], done_val_q[0], done_terr_q[0], t0 + 67);
        end
        run_until_done(2, 60, "timeout_next");
        check_beats("timeout_next");
        checks++;
        if (done_val_q[1] !== 2'b10 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next: done %b terr %b, required 10 and sticky 1", done_val_q[1], timeout_err);
        end
`else
        repeat (80) cycle();
        checks++;
        if (done_val_q.size() !== 0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: dones=%0d terr=%b, required 0 and 0", done_val_q.size(), timeout_err);
        end
        for (int i = 0; i < 4; i++) exp_q.push_front(mk_beat(0, 3 - i));
        prod_left[0] = 4;
        run_until_done(2, 80, "stall_resume");
        check_beats("stall_resume");
        checks++;
        if (done_val_q[0] !== 2'b01 || done_val_q[1] !== 2'b10) begin
            errors++;
            $display("FAIL stall_done: %b,%b required 01,10", done_val_q[0], done_val_q[1]);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_overrun();
        test_zero_size();
        test_backpressure();
        test_reset_mid();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wmst_burst_arbiter.md
Name: wmst_burst_arbiter

Overview:
- Shares one write-master command port and one 512-bit output stream between NUM_REQ burst producers, e.g. several OFM flatteners.
- Each producer raises a one-cycle burst request with an address and byte size, streams its beats, and waits for completion.
- The arbiter latches requests and grants them round-robin, one burst at a time.
- It forwards the granted producer's command and stream, limits the stream to the burst length, and returns a per-producer done pulse.

Parameters:
- NUM_REQ, 2, number of producers (2..4).
- DATA_W, 512, stream beat width in bits.
- BEAT_BYTES, 64, bytes per beat (DATA_W/8).
- TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  one-cycle burst request pulse per producer
- req_addr_i  in  NUM_REQ*64  burst start address; producer k uses bits [64k+63:64k]
- req_size_i  in  NUM_REQ*64  burst byte size, same packing
- req_done_o  out  NUM_REQ  one-cycle completion pulse per producer
- s_tdata_i  in  NUM_REQ*DATA_W  producer beats
- s_valid_i  in  NUM_REQ  producer beat valid
- s_ready_o  out  NUM_REQ  producer beat ready
- m_wmst_req  out  1  command pulse to the write master
- m_wmst_addr  out  64  latched burst address
- m_wmst_xfer_size  out  64  latched burst size
- m_wmst_done  in  1  write-master completion pulse
- m_tdata  out  DATA_W  forwarded beat
- m_valid  out  1  forwarded valid
- m_ready  in  1  downstream ready
- grant_id  out  2  index of the current or last granted producer
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending bits 0; round-robin pointer 0; beat counter 0.
- Pending: a req_i[k] pulse sets pending[k] on the next edge. A pulse from a producer that is already pending, or already granted, is held as one pending bit. It is not dropped and not double-counted.
  - Exception: a granted producer pulsing during DONE re-arms for a later grant.
- IDLE: if any pending bit is set, grant the first set bit at or after the pointer, searching with wrap-around.
  - Latch that producer's addr and size.
  - Compute beats = ceil(size/BEAT_BYTES).
  - Go to ISSUE.
  - If size == 0: no command is issued; go straight to DONE.
- ISSUE: m_wmst_req = 1 for exactly this one cycle, then go to XFER. m_wmst_addr and m_wmst_xfer_size stay stable from ISSUE until leaving DONE.
- XFER stream routing:
  - m_tdata = s_tdata of the granted producer; m_valid = s_valid[grant] AND (sent < beats).
  - s_ready[grant] = m_ready AND (sent < beats); s_ready of every other producer is 0.
  - sent increments on each m_valid & m_ready.
  - Once sent == beats, the stream is blocked: extra producer beats stay in the producer FIFO.
- XFER exit: m_wmst_done moves XFER to DONE. If m_wmst_done arrives in the ISSUE cycle, it is accepted and the FSM goes to DONE directly.
- DONE, one cycle:
  - req_done_o[grant] = 1 for one cycle.
  - Clear pending[grant], except a simultaneous re-request re-arms it.
  - Pointer = grant+1 mod NUM_REQ; sent = 0; return to IDLE.
- Ignored inputs: m_wmst_done in IDLE or DONE is ignored. Inputs with index >= NUM_REQ are unused.
- Latency: a req pulse at cycle t against an idle arbiter gives m_wmst_req at t+2.
- Minimum back-to-back gap between commands: 3 cycles (DONE, IDLE, ISSUE).
- Reset mid-burst: the asynchronous clear returns everything to reset values; in-flight pending requests are lost.

Optional Feature:
- Macro WMST_ARB_TIMEOUT_EN.
- When defined: a cycle counter runs in XFER and clears on every accepted beat.
  - If it reaches TIMEOUT, timeout_err sets; it stays set until reset.
  - The FSM also forces DONE without waiting for m_wmst_done.
- When undefined: timeout_err is tied to 0 and no counter logic exists.

Test Plan:
- Single request: req_i=01, addr=0x1000, size=1024, m_ready=1, 16 valid beats, done after the last beat -> m_wmst_req at t+2; addr 0x1000; size 1024; exactly 16 beats forwarded; req_done_o=01 one cycle.
- Contention: req_i=11 in the same cycle -> producer 0 served first, then producer 1; grant_id 0 then 1; no beats from producer 1 reach m_tdata during the first burst.
- Round-robin fairness: producers 0 and 1 re-request immediately after each done, 6 bursts -> grant sequence 0,1,0,1,0,1.
- Overrun block: producer holds s_valid=1 for 20 beats, size=1024 -> s_ready drops after beat 16; the remaining 4 beats are not consumed.
- Zero size plus backpressure:
  - size=0 -> no m_wmst_req; req_done pulse at t+2.
  - Separate burst with m_ready toggled 50% -> beats arrive in order; sent reaches 16 before done.
- Timeout (with WMST_ARB_TIMEOUT_EN, TIMEOUT=64): m_wmst_done never asserts -> timeout_err=1 after 64 idle XFER cycles; req_done pulse follows; the next pending request is served.
